// File: rtl/line_delay_fifo.sv
// rtl/line_delay_fifo.sv - runtime-programmable sample-count delay line for one window-buffer row
// Re-emits each accepted pixel exactly N accepts later; N latched at reset release and on every i_sof.
module line_delay_fifo #(
    parameter int PXL_CHANNEL  = 8,
    parameter int NUM_CHANNELS = 3,
    parameter int MAX_DEPTH    = 2048,
    localparam int DW          = $clog2(MAX_DEPTH + 1)
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset_n,
    input  logic                                      i_sof,
    input  logic [DW-1:0]                             i_depth,
    input  logic                                      i_enable_rx,
    input  logic [NUM_CHANNELS-1:0][PXL_CHANNEL-1:0]  i_data,
    output logic                                      o_enable_tx,
    output logic [NUM_CHANNELS-1:0][PXL_CHANNEL-1:0]  o_data,
    output logic                                      o_primed,
    output logic [DW-1:0]                             o_fill,
    output logic                                      o_depth_err
);

    localparam int AW = $clog2(MAX_DEPTH);
    localparam int WW = NUM_CHANNELS * PXL_CHANNEL;
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] ONE_D = DW'(1);

    typedef enum logic [1:0] {IDLE, FILL, PRIMED} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt, wr_addr;
    logic [DW-1:0] r_depth, depth_nxt, fill_nxt, new_depth;
    logic          err_nxt, depth_bad, we, re;
    logic          rd_vld;
    logic [WW-1:0] rd_q;
    logic [WW-1:0] mem [MAX_DEPTH];

    always_comb begin
        depth_bad = (i_depth == '0) || (i_depth > MAX_D);
        new_depth = depth_bad ? MAX_D : i_depth;
    end

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        fill_nxt   = o_fill;
        depth_nxt  = r_depth;
        err_nxt    = o_depth_err;
        wr_addr    = wr_ptr;
        we         = 1'b0;
        re         = 1'b0;
        if (state == IDLE || i_sof) begin
            // Flush: new depth takes effect immediately, so a sample in this cycle opens the new frame
            depth_nxt  = new_depth;
            err_nxt    = depth_bad;
            state_nxt  = FILL;
            wr_ptr_nxt = '0;
            fill_nxt   = '0;
            wr_addr    = '0;
            if (i_sof && i_enable_rx) begin
                we       = 1'b1;
                fill_nxt = ONE_D;
                if (new_depth == ONE_D) begin
                    state_nxt = PRIMED;
                end else begin
                    wr_ptr_nxt = AW'(1);
                end
            end
        end else if (i_enable_rx) begin
            we         = 1'b1;
            wr_ptr_nxt = (DW'(wr_ptr) == r_depth - ONE_D) ? '0 : wr_ptr + AW'(1);
            if (state == FILL) begin
                fill_nxt = o_fill + ONE_D;
                if (o_fill == r_depth - ONE_D) begin
                    state_nxt = PRIMED;
                end
            end else begin
                re = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            r_depth     <= MAX_D;
            o_fill      <= '0;
            o_depth_err <= 1'b0;
            o_enable_tx <= 1'b0;
            rd_vld      <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            r_depth     <= depth_nxt;
            o_fill      <= fill_nxt;
            o_depth_err <= err_nxt;
            o_enable_tx <= re;
            if (re) begin
                rd_vld <= 1'b1;
            end
        end
    end

    // Read-before-write on the same address: the old entry is exactly N accepts old
    always_ff @(posedge i_clk) begin
        if (re) begin
            rd_q <= mem[wr_ptr];
        end
        if (we) begin
            mem[wr_addr] <= i_data;
        end
    end

    assign o_data   = rd_vld ? rd_q : '0;
    assign o_primed = (state == PRIMED);

endmodule

// File: tb/tb_line_delay_fifo.sv
// tb/tb_line_delay_fifo.sv - directed self-checking bench for line_delay_fifo
module tb_line_delay_fifo;

    localparam int PXL_CHANNEL  = 8;
    localparam int NUM_CHANNELS = 3;
    localparam int MAX_DEPTH    = 8;
    localparam int DW           = $clog2(MAX_DEPTH + 1);
    localparam int WW           = NUM_CHANNELS * PXL_CHANNEL;

    logic                                     i_clk;
    logic                                     i_reset_n;
    logic                                     i_sof;
    logic [DW-1:0]                            i_depth;
    logic                                     i_enable_rx;
    logic [NUM_CHANNELS-1:0][PXL_CHANNEL-1:0] i_data;
    logic                                     o_enable_tx;
    logic [NUM_CHANNELS-1:0][PXL_CHANNEL-1:0] o_data;
    logic                                     o_primed;
    logic [DW-1:0]                            o_fill;
    logic                                     o_depth_err;

    int n_checks = 0;
    int n_pass   = 0;

    line_delay_fifo #(
        .PXL_CHANNEL (PXL_CHANNEL),
        .NUM_CHANNELS(NUM_CHANNELS),
        .MAX_DEPTH   (MAX_DEPTH)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_sof      (i_sof),
        .i_depth    (i_depth),
        .i_enable_rx(i_enable_rx),
        .i_data     (i_data),
        .o_enable_tx(o_enable_tx),
        .o_data     (o_data),
        .o_primed   (o_primed),
        .o_fill     (o_fill),
        .o_depth_err(o_depth_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic sof, input logic en, input int data, input int depth);
        i_sof       = sof;
        i_enable_rx = en;
        i_data      = WW'(data);
        i_depth     = DW'(depth);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset_n   = 1'b0;
        i_sof       = 1'b0;
        i_enable_rx = 1'b0;
        i_data      = '0;
        i_depth     = '0;

        // T1: reset with random inputs
        repeat (3) begin
            i_sof       = 1'($urandom);
            i_enable_rx = 1'($urandom);
            i_data      = WW'($urandom);
            i_depth     = DW'($urandom);
            @(posedge i_clk);
            #1;
        end
        check_eq("rst_tx",     32'(o_enable_tx), 32'd0);
        check_eq("rst_data",   32'(o_data),      32'd0);
        check_eq("rst_primed", 32'(o_primed),    32'd0);
        check_eq("rst_fill",   32'(o_fill),      32'd0);
        check_eq("rst_err",    32'(o_depth_err), 32'd0);
        i_sof       = 1'b0;
        i_enable_rx = 1'b0;
        i_depth     = DW'(4);
        i_reset_n   = 1'b1;
        step(1'b0, 1'b0, 0, 4);
        check_eq("rel_fill",   32'(o_fill),      32'd0);
        check_eq("rel_primed", 32'(o_primed),    32'd0);
        check_eq("rel_err",    32'(o_depth_err), 32'd0);

        // T2: N=4, continuous 1,2,3,...
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, k, 4);
            check_eq("t2_tx", 32'(o_enable_tx), 32'(k >= 5));
            if (k >= 5) check_eq("t2_data", 32'(o_data), 32'(k - 4));
            if (k == 3) check_eq("t2_primed3", 32'(o_primed), 32'd0);
            if (k == 4) begin
                check_eq("t2_primed4", 32'(o_primed), 32'd1);
                check_eq("t2_fill4",   32'(o_fill),   32'd4);
            end
        end

        // T3: N=4 with gaps, samples 10..14 on alternate cycles
        step(1'b1, 1'b0, 0, 4);
        check_eq("t3_flush_primed", 32'(o_primed),    32'd0);
        check_eq("t3_flush_fill",   32'(o_fill),      32'd0);
        check_eq("t3_flush_tx",     32'(o_enable_tx), 32'd0);
        for (int i = 0; i <= 8; i++) begin
            step(1'b0, 1'((i % 2) == 0), 10 + i / 2, 4);
            check_eq("t3_tx", 32'(o_enable_tx), 32'(i == 8));
        end
        check_eq("t3_data", 32'(o_data), 32'd10);
        step(1'b0, 1'b0, 'h77, 4);
        check_eq("t3_idle_tx",   32'(o_enable_tx), 32'd0);
        check_eq("t3_hold_data", 32'(o_data),      32'd10);

        // T4: N=1
        step(1'b1, 1'b0, 0, 1);
        step(1'b0, 1'b1, 'hA1, 1);
        check_eq("t4_a_tx",     32'(o_enable_tx), 32'd0);
        check_eq("t4_a_primed", 32'(o_primed),    32'd1);
        check_eq("t4_a_fill",   32'(o_fill),      32'd1);
        step(1'b0, 1'b1, 'hB2, 1);
        check_eq("t4_b_tx",   32'(o_enable_tx), 32'd1);
        check_eq("t4_b_data", 32'(o_data),      32'hA1);
        step(1'b0, 1'b1, 'hC3, 1);
        check_eq("t4_c_tx",   32'(o_enable_tx), 32'd1);
        check_eq("t4_c_data", 32'(o_data),      32'hB2);

        // T4: N=MAX_DEPTH with wrap
        step(1'b1, 1'b0, 0, MAX_DEPTH);
        check_eq("t4_max_err", 32'(o_depth_err), 32'd0);
        for (int k = 0; k <= 2 * MAX_DEPTH; k++) begin
            step(1'b0, 1'b1, 100 + k, MAX_DEPTH);
            check_eq("t4_max_tx", 32'(o_enable_tx), 32'(k >= MAX_DEPTH));
            if (k >= MAX_DEPTH) check_eq("t4_max_data", 32'(o_data), 32'(100 + k - MAX_DEPTH));
        end

        // T5: mid-frame sof with accept in the sof cycle
        step(1'b1, 1'b0, 0, 4);
        for (int k = 0; k <= 5; k++) step(1'b0, 1'b1, 'h20 + k, 4);
        check_eq("t5_pre_tx",   32'(o_enable_tx), 32'd1);
        check_eq("t5_pre_data", 32'(o_data),      32'h21);
        step(1'b1, 1'b1, 'h50, 3);
        check_eq("t5_sof_primed", 32'(o_primed),    32'd0);
        check_eq("t5_sof_fill",   32'(o_fill),      32'd1);
        check_eq("t5_sof_tx",     32'(o_enable_tx), 32'd0);
        step(1'b0, 1'b1, 'h51, 3);
        check_eq("t5_51_tx", 32'(o_enable_tx), 32'd0);
        step(1'b0, 1'b1, 'h52, 3);
        check_eq("t5_52_tx",     32'(o_enable_tx), 32'd0);
        check_eq("t5_52_primed", 32'(o_primed),    32'd1);
        check_eq("t5_52_fill",   32'(o_fill),      32'd3);
        step(1'b0, 1'b1, 'h53, 3);
        check_eq("t5_53_tx",   32'(o_enable_tx), 32'd1);
        check_eq("t5_53_data", 32'(o_data),      32'h50);

        // T6: illegal depths clamp to MAX_DEPTH and set the sticky error
        step(1'b1, 1'b0, 0, 0);
        check_eq("t6_err0", 32'(o_depth_err), 32'd1);
        for (int k = 0; k <= MAX_DEPTH; k++) begin
            step(1'b0, 1'b1, 200 + k, 0);
            if (k == MAX_DEPTH - 1) begin
                check_eq("t6_last_fill_tx", 32'(o_enable_tx), 32'd0);
                check_eq("t6_fill",         32'(o_fill),      32'(MAX_DEPTH));
            end
        end
        check_eq("t6_tx",   32'(o_enable_tx), 32'd1);
        check_eq("t6_data", 32'(o_data),      32'd200);
        step(1'b1, 1'b0, 0, MAX_DEPTH + 1);
        check_eq("t6_err_big", 32'(o_depth_err), 32'd1);
        step(1'b1, 1'b0, 0, 8);
        check_eq("t6_err_clr", 32'(o_depth_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
